// File: rtl/fold_reduce_pkg.sv
// Shared types and default parameters for the fold_reduce modular reducer
// (residue mod 2^W - C).
package fold_reduce_pkg;

   localparam int DEF_W         = 128;
   localparam int DEF_PW        = 384;
   localparam int DEF_CW        = 64;
   localparam int DEF_MAX_FOLDS = 6;
   localparam logic [DEF_CW-1:0] DEF_C = 64'd159;

   // One guard bit above the product width keeps every fold sum exact.
   localparam int DEF_AW = DEF_PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FOLD  = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fold_reduce_fold_step.sv
// Combinational single fold: a_out = a_in mod 2^W + floor(a_in / 2^W) * C,
// with a flag that is set when a_out already fits in W bits.
module fold_step
   import fold_reduce_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int PW = DEF_PW,
   parameter int CW = DEF_CW,
   parameter logic [CW-1:0] C = DEF_C
) (
   input  logic [PW:0] a_in,
   output logic [PW:0] a_out,
   output logic        hi_zero
);

   localparam int AW  = PW + 1;
   localparam int HW  = AW - W;
   localparam int PRW = HW + CW;

   logic [HW-1:0]  hi;
   logic [PRW-1:0] prod;

   assign hi   = a_in[AW-1:W];
   // Full-width product: nothing is dropped while the high part is nonzero.
   assign prod = PRW'(hi) * PRW'(C);

   assign a_out   = AW'(a_in[W-1:0]) + AW'(prod);
   assign hi_zero = (a_out[AW-1:W] == '0);

endmodule

// File: rtl/fold_reduce.sv
// Reduces a PW-bit product modulo M = 2^W - C by repeated folding and a final
// conditional subtraction. FOLD_REDUCE_CONST_TIME_EN: run a fixed MAX_FOLDS folds.
module fold_reduce
   import fold_reduce_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int PW        = DEF_PW,
   parameter int CW        = DEF_CW,
   parameter logic [CW-1:0] C = DEF_C,
   parameter int MAX_FOLDS = DEF_MAX_FOLDS
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] P,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  R,
   output state_t        dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; once valid is raised its data holds stable until that edge.

   localparam int AW = PW + 1;

   state_t        state;
   logic [AW-1:0] acc;
   logic [AW-1:0] fold_out;
   logic          hi_zero;
   logic [W:0]    sub_sum;

   fold_step #(
      .W  (W),
      .PW (PW),
      .CW (CW),
      .C  (C)
   ) u_fold_step (
      .a_in    (acc),
      .a_out   (fold_out),
      .hi_zero (hi_zero)
   );

   // acc >= M exactly when acc + C carries out of W bits; the low W bits of
   // that sum are then acc - M.
   assign sub_sum   = {1'b0, acc[W-1:0]} + (W+1)'(C);
   assign dbg_state = state;

`ifdef FOLD_REDUCE_CONST_TIME_EN
   logic [2:0] fold_cnt;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         acc       <= '0;
         R         <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
`ifdef FOLD_REDUCE_CONST_TIME_EN
         fold_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc      <= AW'(P);
                  in_ready <= 1'b0;
                  state    <= FOLD;
`ifdef FOLD_REDUCE_CONST_TIME_EN
                  fold_cnt <= '0;
`endif
               end
            end
            FOLD: begin
               acc <= fold_out;
`ifdef FOLD_REDUCE_CONST_TIME_EN
               fold_cnt <= fold_cnt + 3'd1;
               if (fold_cnt == 3'(MAX_FOLDS - 1)) state <= FINAL;
`else
               if (hi_zero) state <= FINAL;
`endif
            end
            FINAL: begin
               R         <= sub_sum[W] ? sub_sum[W-1:0] : acc[W-1:0];
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fold_reduce.sv
// Bench for fold_reduce: directed corner values, backpressure, mid-fold reset
// and randomized products checked against a big-integer P mod M model.
module tb_fold_reduce;
   import fold_reduce_pkg::*;

   localparam int W  = 128;
   localparam int PW = 384;
   localparam int N_RANDOM = 2000;
   localparam int CT_LAT = 7;

   logic          clock;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] P;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  R;
   state_t        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   logic [PW-1:0] modulus;
   logic [PW-1:0] two_w;
   logic [PW-1:0] ones_w;

   fold_reduce dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .P         (P),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (R),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model: plain big-integer remainder
   function automatic logic [W-1:0] model(input logic [PW-1:0] p);
      return W'(p % modulus);
   endfunction

   function automatic logic [PW-1:0] rand_p();
      logic [PW-1:0] v;
      for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
         0: v = v >> $urandom_range(0, PW - 1);
         1: v = modulus - PW'(200) + PW'($urandom_range(0, 400));
         default: ;
      endcase
      return v;
   endfunction

   // driver: one full transaction; bp < 0 means random out_ready,
   // otherwise out_ready is held low for bp cycles after out_valid rises.
   task automatic do_op(input string tag, input logic [PW-1:0] p,
                        input logic [W-1:0] exp_r, input int bp);
      int guard;
      int lat;
      logic [W-1:0] want;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      check({tag, "_in_ready"}, PW'(in_ready), PW'(1));
      in_valid = 1'b1;
      P        = p;
      exp_q.push_back(exp_r);
      tick();
      in_valid = 1'b0;
      P        = rand_p();
      check({tag, "_busy"}, PW'(in_ready), PW'(0));

      lat = 0;
      while (!out_valid && lat < 40) begin
         out_ready = (bp < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         lat++;
      end
`ifdef FOLD_REDUCE_CONST_TIME_EN
      check({tag, "_lat"}, PW'(lat), PW'(CT_LAT));
`else
      if (p < two_w) check({tag, "_lat"}, PW'(lat), PW'(2));
      else check({tag, "_lat_range"}, PW'(lat >= 2 && lat <= CT_LAT), PW'(1));
`endif

      want = exp_q[0];
      if (bp >= 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            P        = rand_p();
            tick();
            check({tag, "_bp_r"}, PW'(R), PW'(want));
            check({tag, "_bp_valid"}, PW'(out_valid), PW'(1));
            check({tag, "_bp_in_ready"}, PW'(in_ready), PW'(0));
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end else begin
         guard = 0;
         while (!out_ready && guard < 40) begin
            tick();
            guard++;
            check({tag, "_hold_r"}, PW'(R), PW'(want));
            check({tag, "_hold_valid"}, PW'(out_valid), PW'(1));
            out_ready = 1'($urandom_range(0, 1));
         end
         out_ready = 1'b1;
      end

      // scoreboard
      want = exp_q.pop_front();
      check({tag, "_r"}, PW'(R), PW'(want));
      tick();
      check({tag, "_post_valid"}, PW'(out_valid), PW'(0));
      check({tag, "_post_in_ready"}, PW'(in_ready), PW'(1));
      out_ready = (bp < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   initial begin
      modulus = (PW'(1) << W) - PW'(159);
      two_w   = PW'(1) << W;
      ones_w  = (PW'(1) << W) - PW'(1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      P         = '0;
      reset     = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("rst_in_ready", PW'(in_ready), PW'(1));
      check("rst_out_valid", PW'(out_valid), PW'(0));
      check("rst_r", PW'(R), PW'(0));
      check("rst_state", PW'(dbg_state), PW'(IDLE));

      do_op("zero", '0, 128'd0, 0);
      do_op("eq_mod", modulus, 128'd0, 0);
      do_op("two_w", two_w, 128'd159, 0);
      do_op("ones_sq", ones_w * ones_w, 128'd24964, 0);
      do_op("all_ones", '1, 128'd4019678, 0);

      // reset during the second fold cycle
      in_valid = 1'b1;
      P        = '1;
      tick();
      in_valid = 1'b0;
      tick();
      check("mid_state", PW'(dbg_state), PW'(FOLD));
      reset = 1'b0;
      #1;
      check("mid_rst_valid", PW'(out_valid), PW'(0));
      check("mid_rst_r", PW'(R), PW'(0));
      check("mid_rst_state", PW'(dbg_state), PW'(IDLE));
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("mid_rel_in_ready", PW'(in_ready), PW'(1));
      check("mid_rel_valid", PW'(out_valid), PW'(0));
      check("mid_rel_r", PW'(R), PW'(0));
      exp_q.delete();
      do_op("after_rst", two_w, 128'd159, 0);

      begin
         logic [PW-1:0] pv;
         pv = rand_p();
         do_op("backpressure", pv, model(pv), 5);
      end

      for (int n = 0; n < N_RANDOM; n++) begin
         logic [PW-1:0] pv;
         pv = rand_p();
         do_op("rand", pv, model(pv), -1);
      end

      check("queue_empty", PW'(exp_q.size()), PW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
